// File: rtl/uart_wb_master_pkg.sv
// uart_wb_master shared definitions: command/reply codes, FSM states
// and the baud divider helper.
package uart_wb_master_pkg;

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h45;
    localparam logic [7:0] RSP_BAD = 8'h3F;
    localparam logic [7:0] RSP_TMO = 8'h54;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_BUS,
        ST_REPLY
    } state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_wb_master_phy.sv
// uart_wb_master serial PHY: 2-flop RX synchronizer + 8N1 deserializer
// with glitch/framing rejection, and 8N1 TX serializer.
module uart_wb_master_phy
    import uart_wb_master_pkg::*;
#(
    parameter int unsigned DIV = 208
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_i,
    output logic       tx_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_load_i,
    output logic       tx_ready_o
);

    localparam int unsigned CW = $clog2(DIV + 1);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);

    logic            sync1_q, sync2_q, prev_q;
    rx_state_e       rx_st_q, rx_st_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_sh_q, rx_sh_d;
    logic            rx_vld_q, rx_vld_d;

    logic            tx_busy_q, tx_busy_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [3:0]      tx_n_q, tx_n_d;
    logic [9:0]      tx_sh_q, tx_sh_d;

    assign rx_data_o  = rx_sh_q;
    assign rx_valid_o = rx_vld_q;
    assign tx_o       = tx_busy_q ? tx_sh_q[0] : 1'b1;
    assign tx_ready_o = !tx_busy_q;

    // RX deserializer: edge detect, mid-start recheck, mid-bit sampling
    always_comb begin
        rx_st_d  = rx_st_q;
        rx_cnt_d = rx_cnt_q;
        rx_bit_d = rx_bit_q;
        rx_sh_d  = rx_sh_q;
        rx_vld_d = 1'b0;
        unique case (rx_st_q)
            RX_IDLE: begin
                if (prev_q && !sync2_q) begin
                    rx_st_d  = RX_START;
                    rx_cnt_d = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_M1) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    rx_st_d  = sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == DIV_M1) begin
                    rx_cnt_d = '0;
                    rx_sh_d  = {sync2_q, rx_sh_q[7:1]};
                    rx_bit_d = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_st_d = RX_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == DIV_M1) begin
                    rx_vld_d = sync2_q;
                    rx_st_d  = RX_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_st_d = RX_IDLE;
        endcase
    end

    // TX serializer: start, 8 data LSB first, stop, DIV cycles each
    always_comb begin
        tx_busy_d = tx_busy_q;
        tx_cnt_d  = tx_cnt_q;
        tx_n_d    = tx_n_q;
        tx_sh_d   = tx_sh_q;
        if (!tx_busy_q) begin
            if (tx_load_i) begin
                tx_busy_d = 1'b1;
                tx_sh_d   = {1'b1, tx_data_i, 1'b0};
                tx_cnt_d  = '0;
                tx_n_d    = '0;
            end
        end else if (tx_cnt_q == DIV_M1) begin
            tx_cnt_d = '0;
            tx_sh_d  = {1'b1, tx_sh_q[9:1]};
            tx_n_d   = tx_n_q + 4'd1;
            if (tx_n_q == 4'd9) begin
                tx_busy_d = 1'b0;
            end
        end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
        end
    end

    // State registers; line side resets to idle-high
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            rx_st_q   <= RX_IDLE;
            rx_cnt_q  <= '0;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
            rx_vld_q  <= 1'b0;
            tx_busy_q <= 1'b0;
            tx_cnt_q  <= '0;
            tx_n_q    <= '0;
            tx_sh_q   <= '1;
        end else begin
            sync1_q   <= rx_i;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            rx_st_q   <= rx_st_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_bit_q  <= rx_bit_d;
            rx_sh_q   <= rx_sh_d;
            rx_vld_q  <= rx_vld_d;
            tx_busy_q <= tx_busy_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_n_q    <= tx_n_d;
            tx_sh_q   <= tx_sh_d;
        end
    end

endmodule

// File: rtl/uart_wb_master.sv
// uart_wb_master: UART command packets -> one Wishbone classic access.
// Optional ack timeout enabled by defining UART_WB_MASTER_TIMEOUT_EN.
module uart_wb_master
    import uart_wb_master_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ    = 24000000,
    parameter int unsigned BAUD           = 115200,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        uart_rx_i,
    output logic        uart_tx_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        busy_o
);

    localparam int unsigned DIV = calc_div(CLK_FREQ_HZ, BAUD);

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        tx_ready;
    logic        tx_load;
    logic [7:0]  tx_byte;

    state_e      state_q, state_d;
    logic        is_wr_q, is_wr_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic        cyc_q, cyc_d;
    logic [31:0] rsp_q, rsp_d;
    logic [2:0]  rsp_n_q, rsp_n_d;

`ifdef UART_WB_MASTER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_M1 = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_q, tmo_d;
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

    uart_wb_master_phy #(
        .DIV (DIV)
    ) u_phy (
        .clock      (clock),
        .reset      (reset),
        .rx_i       (uart_rx_i),
        .tx_o       (uart_tx_o),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .tx_data_i  (tx_byte),
        .tx_load_i  (tx_load),
        .tx_ready_o (tx_ready)
    );

    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_sel_o = {4{cyc_q}};
    assign wb_we_o  = cyc_q & is_wr_q;
    assign busy_o   = (state_q != ST_IDLE) | ~tx_ready;
    assign tx_byte  = rsp_q[31:24];

    // Command FSM: parse packet, run bus cycle, stream reply bytes
    always_comb begin
        state_d = state_q;
        is_wr_d = is_wr_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        cyc_d   = cyc_q;
        rsp_d   = rsp_q;
        rsp_n_d = rsp_n_q;
        tx_load = 1'b0;
`ifdef UART_WB_MASTER_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                        state_d = ST_ADDR;
                        cnt_d   = 2'd0;
                        is_wr_d = (rx_data == CMD_WR);
                    end else begin
                        rsp_d   = {RSP_BAD, 24'h0};
                        rsp_n_d = 3'd1;
                        state_d = ST_REPLY;
                    end
                end
            end
            ST_ADDR: begin
                if (rx_valid) begin
                    adr_d = {adr_q[23:0], rx_data};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = is_wr_q ? ST_DATA : ST_BUS;
                    end
                end
            end
            ST_DATA: begin
                if (rx_valid) begin
                    dat_d = {dat_q[23:0], rx_data};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = ST_BUS;
                    end
                end
            end
            ST_BUS: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1;
`ifdef UART_WB_MASTER_TIMEOUT_EN
                    tmo_d = '0;
`endif
                end else if (wb_err_i) begin
                    cyc_d   = 1'b0;
                    rsp_d   = {RSP_ERR, 24'h0};
                    rsp_n_d = 3'd1;
                    state_d = ST_REPLY;
                end else if (wb_ack_i) begin
                    cyc_d   = 1'b0;
                    state_d = ST_REPLY;
                    if (is_wr_q) begin
                        rsp_d   = {RSP_OK, 24'h0};
                        rsp_n_d = 3'd1;
                    end else begin
                        rsp_d   = wb_dat_i;
                        rsp_n_d = 3'd4;
                    end
`ifdef UART_WB_MASTER_TIMEOUT_EN
                end else if (tmo_q == TMO_M1) begin
                    cyc_d   = 1'b0;
                    rsp_d   = {RSP_TMO, 24'h0};
                    rsp_n_d = 3'd1;
                    state_d = ST_REPLY;
                end else begin
                    tmo_d = tmo_q + 1'b1;
`endif
                end
            end
            ST_REPLY: begin
                if (tx_ready) begin
                    tx_load = 1'b1;
                    rsp_d   = {rsp_q[23:0], 8'h00};
                    rsp_n_d = rsp_n_q - 3'd1;
                    if (rsp_n_q == 3'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and bus registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            is_wr_q <= 1'b0;
            cnt_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            cyc_q   <= 1'b0;
            rsp_q   <= '0;
            rsp_n_q <= '0;
`ifdef UART_WB_MASTER_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            is_wr_q <= is_wr_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            cyc_q   <= cyc_d;
            rsp_q   <= rsp_d;
            rsp_n_q <= rsp_n_d;
`ifdef UART_WB_MASTER_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_wb_master.sv
// Directed testbench for uart_wb_master: UART host driver, TX decoder
// and Wishbone slave model; small DIV to keep runs short.
module tb_uart_wb_master;

    localparam int unsigned CLK_HZ = 1000000;
    localparam int unsigned BAUD   = 100000;
    localparam int unsigned DIV    = CLK_HZ / BAUD;

    logic        clock;
    logic        reset;
    logic        uart_rx_i;
    logic        uart_tx_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        busy_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0] rxq[$];

    int          ack_delay = 3;
    bit          no_ack    = 0;
    bit          err_mode  = 0;
    logic [31:0] rd_data   = 32'h0;
    bit          in_cyc    = 0;
    int          n_cyc     = 0;
    int          cap_len   = 0;
    logic [31:0] cap_adr, cap_dat;
    logic        cap_we;
    logic [3:0]  cap_sel;

    uart_wb_master #(
        .CLK_FREQ_HZ    (CLK_HZ),
        .BAUD           (BAUD),
        .TIMEOUT_CYCLES (1024)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .uart_rx_i (uart_rx_i),
        .uart_tx_o (uart_tx_o),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_dat_i  (wb_dat_i),
        .wb_sel_o  (wb_sel_o),
        .wb_we_o   (wb_we_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_ack_i  (wb_ack_i),
        .wb_err_i  (wb_err_i),
        .busy_o    (busy_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Wishbone slave model: capture cycle attributes, respond after delay
    always @(negedge clock) begin
        if (!reset && wb_cyc_o && wb_stb_o) begin
            if (!in_cyc) begin
                in_cyc  = 1;
                n_cyc   = n_cyc + 1;
                cap_len = 0;
                cap_adr = wb_adr_o;
                cap_dat = wb_dat_o;
                cap_we  = wb_we_o;
                cap_sel = wb_sel_o;
            end
            cap_len = cap_len + 1;
            if (cap_len == ack_delay && !no_ack) begin
                wb_ack_i = 1'b1;
                wb_err_i = err_mode;
                wb_dat_i = rd_data;
            end
        end else begin
            in_cyc   = 0;
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
        end
    end

    // UART TX decoder; bad stop bit pushes bit 8 set
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clock);
            if (!reset && uart_tx_o === 1'b0) begin
                repeat (DIV / 2) @(negedge clock);
                if (uart_tx_o === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (DIV) @(negedge clock);
                        b[i] = uart_tx_o;
                    end
                    repeat (DIV) @(negedge clock);
                    rxq.push_back({~uart_tx_o, b});
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clock);
        uart_rx_i = 1'b0;
        repeat (DIV) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            repeat (DIV) @(negedge clock);
        end
        uart_rx_i = stop;
        repeat (DIV) @(negedge clock);
        uart_rx_i = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic get_byte(input string tag, input logic [7:0] exp);
        int t;
        t = 0;
        while (rxq.size() == 0 && t < 30 * DIV) begin
            @(negedge clock);
            t++;
        end
        chk({tag, "_present"}, 32'(rxq.size() != 0), 32'd1);
        if (rxq.size() != 0) begin
            chk(tag, 32'(rxq.pop_front()), {24'h0, exp});
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy_o && t < 30 * DIV) begin
            @(negedge clock);
            t++;
        end
        repeat (2 * DIV) @(negedge clock);
    endtask

    initial begin
        int c0;
        int t;
        reset     = 1'b1;
        uart_rx_i = 1'b1;
        wb_ack_i  = 1'b0;
        wb_err_i  = 1'b0;
        wb_dat_i  = 32'h0;
        repeat (3) @(negedge clock);

        chk("rst_tx", 32'(uart_tx_o), 32'd1);
        chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
        chk("rst_stb", 32'(wb_stb_o), 32'd0);
        chk("rst_we", 32'(wb_we_o), 32'd0);
        chk("rst_adr", wb_adr_o, 32'h0);
        chk("rst_dat", wb_dat_o, 32'h0);
        chk("rst_sel", 32'(wb_sel_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // Write 0xDEADBEEF to 0x1000, ack after 3 cycles
        c0 = n_cyc;
        ack_delay = 3;
        send_byte(8'h57, 1'b1);
        chk("wr_busy", 32'(busy_o), 32'd1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hEF, 1'b1);
        get_byte("wr_rsp", 8'h4B);
        chk("wr_ncyc", 32'(n_cyc - c0), 32'd1);
        chk("wr_adr", cap_adr, 32'h0000_1000);
        chk("wr_dat", cap_dat, 32'hDEAD_BEEF);
        chk("wr_we", 32'(cap_we), 32'd1);
        chk("wr_sel", 32'(cap_sel), 32'hF);
        chk("wr_len", 32'(cap_len), 32'd3);
        wait_idle();

        // Read from 0x4 returns 0x12345678
        ack_delay = 2;
        rd_data   = 32'h1234_5678;
        send_byte(8'h52, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h04, 1'b1);
        get_byte("rd_b0", 8'h12);
        chk("rd_adr", cap_adr, 32'h0000_0004);
        chk("rd_we", 32'(cap_we), 32'd0);
        chk("rd_sel", 32'(cap_sel), 32'hF);
        get_byte("rd_b1", 8'h34);
        get_byte("rd_b2", 8'h56);
        get_byte("rd_b3", 8'h78);
        chk("rd_busy_hi", 32'(busy_o), 32'd1);
        repeat (DIV) @(negedge clock);
        chk("rd_busy_lo", 32'(busy_o), 32'd0);
        wait_idle();

        // Read with err and ack together: cycle ends on first edge
        ack_delay = 1;
        err_mode  = 1;
        send_byte(8'h52, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h08, 1'b1);
        get_byte("err_rsp", 8'h45);
        chk("err_len", 32'(cap_len), 32'd1);
        repeat (20 * DIV) @(negedge clock);
        chk("err_nodata", 32'(rxq.size()), 32'd0);
        err_mode = 0;
        wait_idle();

        // Bad command, then a good write
        c0 = n_cyc;
        send_byte(8'h41, 1'b1);
        get_byte("bad_rsp", 8'h3F);
        chk("bad_nocyc", 32'(n_cyc - c0), 32'd0);
        wait_idle();
        ack_delay = 1;
        send_byte(8'h57, 1'b1);
        send_byte(8'h80, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
        get_byte("bad_wr_rsp", 8'h4B);
        chk("bad_wr_adr", cap_adr, 32'h8000_0003);
        chk("bad_wr_dat", cap_dat, 32'h0102_0304);
        wait_idle();

        // Framing error on 'W' and a short glitch are both ignored
        c0 = n_cyc;
        send_byte(8'h57, 1'b0);
        repeat (2 * DIV) @(negedge clock);
        chk("frm_busy", 32'(busy_o), 32'd0);
        uart_rx_i = 1'b0;
        repeat (2) @(negedge clock);
        uart_rx_i = 1'b1;
        repeat (2 * DIV) @(negedge clock);
        chk("glitch_busy", 32'(busy_o), 32'd0);
        send_byte(8'h57, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h20, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hCA, 1'b1);
        send_byte(8'hFE, 1'b1);
        send_byte(8'hF0, 1'b1);
        send_byte(8'h0D, 1'b1);
        get_byte("frm_wr_rsp", 8'h4B);
        chk("frm_ncyc", 32'(n_cyc - c0), 32'd1);
        chk("frm_adr", cap_adr, 32'h0000_2000);
        chk("frm_dat", cap_dat, 32'hCAFE_F00D);
        wait_idle();

`ifdef UART_WB_MASTER_TIMEOUT_EN
        // No ack: cyc held exactly 1024 cycles then 'T'
        no_ack = 1;
        send_byte(8'h52, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h0C, 1'b1);
        t = 0;
        while (!wb_cyc_o && t < 20 * DIV) begin
            @(negedge clock);
            t++;
        end
        t = 0;
        while (wb_cyc_o && t < 2000) begin
            @(negedge clock);
            t++;
        end
        chk("tmo_len", 32'(cap_len), 32'd1024);
        get_byte("tmo_rsp", 8'h54);
        no_ack = 0;
        wait_idle();
`endif

        // Reset during a stalled bus cycle
        no_ack = 1;
        send_byte(8'h52, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h10, 1'b1);
        t = 0;
        while (!wb_cyc_o && t < 20 * DIV) begin
            @(negedge clock);
            t++;
        end
        chk("rbus_cyc_hi", 32'(wb_cyc_o), 32'd1);
        reset = 1'b1;
        #1;
        chk("rbus_cyc", 32'(wb_cyc_o), 32'd0);
        chk("rbus_stb", 32'(wb_stb_o), 32'd0);
        chk("rbus_tx", 32'(uart_tx_o), 32'd1);
        @(negedge clock);
        reset  = 1'b0;
        no_ack = 0;
        repeat (3) @(negedge clock);
        chk("rbus_busy", 32'(busy_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
